gt_sort_sequencer: RTL and testbench

// - Frame sorter built around one shared N-bit unsigned greater-than compare (a > b).
// - Loads a frame of up to DEPTH words, bubble-sorts it ascending with one compare per cycle, then streams it out.
// - Sits between a valid/ready producer and a valid/ready consumer.

---
 rtl/gt_sort_if.sv | 38 +++
 rtl/gt_sort_sequencer.sv | 176 +++++++++++++++++
 tb/tb_gt_sort_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gt_sort_if.sv
//==============================================================================
// Module   : gt_sort_if
// Brief    : Producer/consumer valid-ready bundle for the frame sorter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface gt_sort_if #(
    parameter int N     = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic          out_last;
    logic          busy;
    logic [CW-1:0] count;

    // Environment side: drives the input stream and consumes the sorted stream.
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy, count
    );

    // Sorter side.
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, busy, count
    );
endinterface

`default_nettype wire

// File: rtl/gt_sort_sequencer.sv
//==============================================================================
// Module   : gt_sort_sequencer
// Brief    : Loads a frame, bubble-sorts it ascending with one shared a>b
//            compare per cycle, then streams it out. Optional early exit on a
//            swap-free pass is enabled by defining SORT_EARLY_EXIT_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module gt_sort_sequencer #(
    parameter int N     = 8,
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    gt_sort_if.slave    bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SORT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  mem_q [DEPTH];
    logic [N-1:0]  mem_d [DEPTH];
    logic [CW-1:0] count_q, count_d;
    // Compare index during SORT, read index during DRAIN.
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] pass_q, pass_d;
`ifdef SORT_EARLY_EXIT_EN
    logic          swapped_q, swapped_d;
`endif

    logic [IW-1:0] w_idx_p1;
    logic [CW-1:0] w_idx_ext;
    logic [CW-1:0] w_pass_ext;
    logic [CW-1:0] w_count_p1;
    logic [CW-1:0] w_count_m1;
    logic [CW-1:0] w_count_m2;
    logic [N-1:0]  w_lo;
    logic [N-1:0]  w_hi;
    logic          w_gt;
    logic          w_end_pass;
    logic          w_sort_done;
    logic          w_frame_end;
    logic          w_rd_last;

    assign w_idx_p1   = idx_q + IW'(1);
    assign w_idx_ext  = CW'(idx_q);
    assign w_pass_ext = CW'(pass_q);
    assign w_count_p1 = count_q + CW'(1);
    assign w_count_m1 = count_q - CW'(1);
    assign w_count_m2 = count_q - CW'(2);
    assign w_lo       = mem_q[idx_q];
    assign w_hi       = mem_q[w_idx_p1];
    assign w_gt       = (w_lo > w_hi);
    assign w_end_pass = (w_idx_ext == w_count_m2);
    assign w_rd_last  = (w_idx_ext == w_count_m1);
    assign w_frame_end = bus.in_last || (w_count_p1 == CW'(DEPTH));

`ifdef SORT_EARLY_EXIT_EN
    // A pass that moved nothing proves the frame is already ordered.
    assign w_sort_done = (w_pass_ext == w_count_m2) || !(swapped_q || w_gt);
`else
    assign w_sort_done = (w_pass_ext == w_count_m2);
`endif

    always_comb begin
        state_d   = state_q;
        mem_d     = mem_q;
        count_d   = count_q;
        idx_d     = idx_q;
        pass_d    = pass_q;
`ifdef SORT_EARLY_EXIT_EN
        swapped_d = swapped_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (bus.in_valid) begin
                    mem_d[count_q[IW-1:0]] = bus.in_data;
                    count_d = w_count_p1;
                    idx_d   = '0;
                    pass_d  = '0;
`ifdef SORT_EARLY_EXIT_EN
                    swapped_d = 1'b0;
`endif
                    if (w_frame_end) begin
                        state_d = (w_count_p1 == CW'(1)) ? ST_DRAIN : ST_SORT;
                    end
                end
            end
            ST_SORT: begin
                if (w_gt) begin
                    mem_d[idx_q]    = w_hi;
                    mem_d[w_idx_p1] = w_lo;
                end
`ifdef SORT_EARLY_EXIT_EN
                swapped_d = swapped_q | w_gt;
`endif
                if (w_end_pass) begin
                    idx_d  = '0;
                    pass_d = pass_q + IW'(1);
`ifdef SORT_EARLY_EXIT_EN
                    swapped_d = 1'b0;
`endif
                    if (w_sort_done) begin
                        pass_d  = '0;
                        state_d = ST_DRAIN;
                    end
                end else begin
                    idx_d = w_idx_p1;
                end
            end
            ST_DRAIN: begin
                if (bus.out_ready) begin
                    if (w_rd_last) begin
                        idx_d   = '0;
                        count_d = '0;
                        state_d = ST_LOAD;
                    end else begin
                        idx_d = w_idx_p1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            idx_q   <= '0;
            pass_q  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            mem_q   <= mem_d;
        end
    end

`ifdef SORT_EARLY_EXIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swapped_q <= 1'b0;
        end else begin
            swapped_q <= swapped_d;
        end
    end
`endif

    assign bus.in_ready  = (state_q == ST_LOAD);
    assign bus.out_valid = (state_q == ST_DRAIN);
    assign bus.out_data  = (state_q == ST_DRAIN) ? w_lo : '0;
    assign bus.out_last  = (state_q == ST_DRAIN) && w_rd_last;
    assign bus.busy      = (state_q == ST_SORT) || (state_q == ST_DRAIN);
    assign bus.count     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_gt_sort_sequencer.sv
//==============================================================================
// Module   : tb_gt_sort_sequencer
// Brief    : Directed self-checking bench for gt_sort_sequencer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_gt_sort_sequencer;
    localparam int N     = 8;
    localparam int DEPTH = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [7:0] vec   [8];
    logic [7:0] exp_v [8];

    gt_sort_if #(.N(N), .DEPTH(DEPTH)) bus ();

    gt_sort_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_frame(input int n, input bit use_last);
        int guard;
        for (int k = 0; k < n; k++) begin
            guard = 0;
            while (!bus.in_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (!bus.in_ready) begin
                checks++;
                failures++;
                $display("FAIL send_ready word=%0d got in_ready=0 want 1", k);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = vec[k];
            bus.in_last  = use_last && (k == n - 1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic measure_sort(output int cycles);
        cycles = 0;
        while (bus.busy && !bus.out_valid && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic drain(input string name, input int n, input bit bp);
        int k, t, ph;
        bit stalled;
        logic [7:0] held;
        k = 0; t = 0; ph = 0; stalled = 1'b0; held = '0;
        while (k < n && t < 300) begin
            if (stalled) begin
                checks++;
                if (bus.out_data !== held || bus.out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_hold got data=%0h valid=%b want data=%0h valid=1",
                             name, bus.out_data, bus.out_valid, held);
                end
            end
            bus.out_ready = bp ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
            ph++;
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    checks++;
                    if ({bus.out_last, bus.out_data} !== {(k == n - 1), exp_v[k]}) begin
                        failures++;
                        $display("FAIL %s_word%0d got last=%b data=%0h want last=%b data=%0h",
                                 name, k, bus.out_last, bus.out_data, (k == n - 1), exp_v[k]);
                    end
                    k++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = bus.out_data;
                end
            end
            @(negedge clk);
            t++;
        end
        bus.out_ready = 1'b0;
        checks++;
        if (k != n) begin
            failures++;
            $display("FAIL %s_drain_timeout got words=%0d want %0d", name, k, n);
        end
        checks++;
        if ({bus.in_ready, bus.count, bus.out_valid} !== {1'b1, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL %s_return_load got in_ready=%b count=%0d out_valid=%b want 1 0 0",
                     name, bus.in_ready, bus.count, bus.out_valid);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_last, bus.busy, bus.count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got in_ready=%b out_valid=%b data=%0h last=%b busy=%b count=%0d want all 0",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.out_last, bus.busy, bus.count);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_ready got %b want 0", bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_rise got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_sort;
        bit seen;
        vec = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd0, 8'd0, 8'd0};
        send_frame(5, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.out_valid, bus.count} !== {1'b1, 1'b0, 4'd5}) begin
            failures++;
            $display("FAIL midsort_state got busy=%b out_valid=%b count=%0d want 1 0 5",
                     bus.busy, bus.out_valid, bus.count);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_last, bus.busy, bus.count} !== '0) begin
            failures++;
            $display("FAIL midsort_async_reset got in_ready=%b out_valid=%b data=%0h last=%b busy=%b count=%0d want all 0",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.out_last, bus.busy, bus.count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.count} !== {1'b1, 4'd0}) begin
            failures++;
            $display("FAIL midsort_after_release got in_ready=%b count=%0d want 1 0",
                     bus.in_ready, bus.count);
        end
        seen = 1'b0;
        repeat (6) begin
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL midsort_stale_output got out_valid/busy=1 want 0");
        end
    endtask

    task automatic test_basic;
        int cyc;
        vec   = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
        exp_v = '{8'd1, 8'd3, 8'd5, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0};
        send_frame(4, 1'b1);
        checks++;
        if (bus.count !== 4'd4) begin
            failures++;
            $display("FAIL basic_count got %0d want 4", bus.count);
        end
        measure_sort(cyc);
        checks++;
        if (cyc != 9) begin
            failures++;
            $display("FAIL basic_sort_cycles got %0d want 9", cyc);
        end
        drain("basic", 4, 1'b0);
    endtask

    task automatic test_implicit_last;
        int cyc;
        vec   = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        exp_v = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        send_frame(8, 1'b0);
        checks++;
        if ({bus.in_ready, bus.count} !== {1'b0, 4'd8}) begin
            failures++;
            $display("FAIL implicit_last got in_ready=%b count=%0d want 0 8", bus.in_ready, bus.count);
        end
        measure_sort(cyc);
        checks++;
        if (cyc != 49) begin
            failures++;
            $display("FAIL implicit_sort_cycles got %0d want 49", cyc);
        end
        drain("implicit", 8, 1'b0);
    endtask

    task automatic test_single;
        int cyc;
        vec   = '{8'hAA, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        exp_v = '{8'hAA, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        send_frame(1, 1'b1);
        checks++;
        if ({bus.out_valid, bus.out_last, bus.out_data} !== {1'b1, 1'b1, 8'hAA}) begin
            failures++;
            $display("FAIL single_next_cycle got valid=%b last=%b data=%0h want 1 1 aa",
                     bus.out_valid, bus.out_last, bus.out_data);
        end
        measure_sort(cyc);
        checks++;
        if (cyc != 0) begin
            failures++;
            $display("FAIL single_sort_cycles got %0d want 0", cyc);
        end
        drain("single", 1, 1'b0);
    endtask

    task automatic test_backpressure;
        int cyc;
        vec   = '{8'd2, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        exp_v = '{8'd1, 8'd2, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        send_frame(3, 1'b1);
        measure_sort(cyc);
        checks++;
        if (cyc != 4) begin
            failures++;
            $display("FAIL bp_sort_cycles got %0d want 4", cyc);
        end
        drain("bp", 3, 1'b1);
    endtask

    task automatic test_sorted;
        int cyc;
        int want;
`ifdef SORT_EARLY_EXIT_EN
        want = 3;
`else
        want = 9;
`endif
        vec   = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
        exp_v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
        send_frame(4, 1'b1);
        measure_sort(cyc);
        checks++;
        if (cyc != want) begin
            failures++;
            $display("FAIL sorted_sort_cycles got %0d want %0d", cyc, want);
        end
        drain("sorted", 4, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset;
        test_reset_mid_sort;
        test_basic;
        test_implicit_last;
        test_single;
        test_backpressure;
        test_sorted;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
